// File: rtl/lif_pkg.sv
// lif_pkg: shared types and constants for the time-multiplexed LIF update engine.
//   - lif_state_e    : sweep FSM encoding (IDLE / SCAN / DONE)
//   - WIDTH_DEF      : default state/current/threshold width
//   - THRESH_RST_DEF : default threshold loaded at reset
//   - clog2()        : index width helper, usable in parameter expressions
package lif_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int THRESH_RST_DEF = 200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lif_state_e;

  // Ceiling log2; returns 1 for value 2, so an index is never zero bits wide
  // for the supported neuron counts (>= 2).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lif_step.sv
// lif_step: one leaky-integrate-and-fire step, purely combinational.
//   s         in  WIDTH : stored (pre-update) membrane state
//   c         in  WIDTH : latched input current
//   threshold in  WIDTH : firing threshold
//   next      out WIDTH : updated state, saturated at 2^WIDTH-1
//   spk       out 1     : neuron fires this step (s >= threshold)
// A firing neuron drops its leak term, so its state restarts from the current.
module lif_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] next,
  output logic             spk
);

  logic [WIDTH:0] half;
  logic [WIDTH:0] sum;

  // Fire decision, leak term, and saturating WIDTH+1 bit add.
  always_comb begin
    spk  = 1'b0;
    half = '0;
    sum  = '0;
    next = '0;
    if (s >= threshold) begin
      spk  = 1'b1;
      half = '0;
    end else begin
      spk  = 1'b0;
      half = {2'b00, s[WIDTH-1:1]};
    end
    sum = {1'b0, c} + half;
    if (sum[WIDTH]) begin
      next = '1;
    end else begin
      next = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// lif_scheduler: sweeps N_NEURONS neurons through one shared lif_step datapath.
//   clk, reset_n        : clock, synchronous active-low reset
//   tick                : start a sweep (accepted in IDLE only; otherwise sets overrun)
//   current_in          : packed currents, neuron i at [i*WIDTH +: WIDTH], latched on tick
//   cfg_we/cfg_threshold: threshold write, honoured in IDLE when tick is low
//   rd_idx/rd_state     : combinational readback of stored state
//   spike_valid/spike_id/spike_ready : spike event stream (valid/ready)
//   busy                : sweep in progress (SCAN or DONE)
//   done                : one-cycle pulse in the DONE cycle
//   overrun             : sticky, tick seen while not IDLE
// A neuron is committed only when the spike output slot is free, so a held
// spike event stalls the sweep without losing any later event.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 8,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int THRESH_RST = THRESH_RST_DEF,
  localparam int IW        = clog2(N_NEURONS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic [N_NEURONS*WIDTH-1:0] current_in,
  input  logic                       cfg_we,
  input  logic [WIDTH-1:0]           cfg_threshold,
  input  logic [IW-1:0]              rd_idx,
  output logic [WIDTH-1:0]           rd_state,
  output logic                       spike_valid,
  output logic [IW-1:0]              spike_id,
  input  logic                       spike_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

  lif_state_e       state;
  lif_state_e       state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] threshold;
  logic [WIDTH-1:0] state_mem [N_NEURONS];
  logic [WIDTH-1:0] cur_mem   [N_NEURONS];

  logic             slot_free;
  logic             commit;
  logic             take_tick;
  logic             load_cfg;
  logic             tick_overrun;
  logic [WIDTH-1:0] step_next;
  logic             step_spk;

  assign slot_free = !spike_valid || spike_ready;

  lif_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .s        (state_mem[idx]),
    .c        (cur_mem[idx]),
    .threshold(threshold),
    .next     (step_next),
    .spk      (step_spk)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a stalled SCAN simply holds.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        if (slot_free && (idx == LAST_IDX)) begin
          state_next = DONE;
        end else begin
          state_next = SCAN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM output decode: status flags and datapath enables.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    commit       = 1'b0;
    take_tick    = 1'b0;
    load_cfg     = 1'b0;
    tick_overrun = 1'b0;
    case (state)
      IDLE: begin
        take_tick = tick;
        load_cfg  = cfg_we && !tick;   // tick wins over a simultaneous write
      end
      SCAN: begin
        busy         = 1'b1;
        commit       = slot_free;
        tick_overrun = tick;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        tick_overrun = tick;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Current latch on an accepted tick and state write-back on commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_mem[i] <= '0;
        cur_mem[i]   <= '0;
      end
    end else begin
      if (take_tick) begin
        for (int i = 0; i < N_NEURONS; i++) begin
          cur_mem[i] <= current_in[i*WIDTH +: WIDTH];
        end
      end
      if (commit) begin
        state_mem[idx] <= step_next;
      end
    end
  end

  // Sweep index: cleared on tick, advanced on each commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (take_tick) begin
      idx <= '0;
    end else if (commit) begin
      if (idx == LAST_IDX) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      idx <= idx;
    end
  end

  // Threshold register, writable only from IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      threshold <= WIDTH'(THRESH_RST);
    end else if (load_cfg) begin
      threshold <= cfg_threshold;
    end else begin
      threshold <= threshold;
    end
  end

  // Spike output slot: loaded on a firing commit, cleared once accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spike_valid <= 1'b0;
      spike_id    <= '0;
    end else if (commit) begin
      spike_valid <= step_spk;
      if (step_spk) begin
        spike_id <= idx;
      end else begin
        spike_id <= spike_id;
      end
    end else if (spike_ready) begin
      spike_valid <= 1'b0;
    end else begin
      spike_valid <= spike_valid;
    end
  end

  // Sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (tick_overrun) begin
      overrun <= 1'b1;
    end else begin
      overrun <= overrun;
    end
  end

  // Readback mux; out-of-range indices read as zero.
  always_comb begin
    rd_state = '0;
    if (32'(rd_idx) < N_NEURONS) begin
      rd_state = state_mem[rd_idx];
    end else begin
      rd_state = '0;
    end
  end

endmodule
